// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: RV32I fetch with in-order response queue and IF/ID register
//   clk, reset                      : clock, synchronous active-high reset
//   StallD, FlushD                  : hold / bubble controls for the IF/ID register
//   PCSrcE, PCTargetE               : redirect request and target from execute
//   imem_req_valid/addr/ready       : non-sticky fetch request, address is PCF
//   imem_rsp_valid/data             : instruction words returned in request order
//   InstrD, PCD, PCPlus4D, ValidD   : decode-stage outputs
module fetch_queue_stage #(
    parameter int XLEN = 32,
    parameter int DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] pcF, rspPc, targetF;
    logic [31:0]     qInstr [DEPTH];
    logic [XLEN-1:0] qPc [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count, outstanding, dropCnt;
    logic            fire, push, pop, bubble;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Credits cover queued words plus every in-flight request, stale ones included,
    // so a returning word always has a free slot.
    assign imem_req_valid = !reset && !PCSrcE &&
                            (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
    assign imem_req_addr  = pcF;
    assign fire           = imem_req_valid && imem_req_ready;
    assign targetF        = PCTargetE & ~XLEN'(3);
    // A word arriving during a redirect belongs to the old path.
    assign push           = imem_rsp_valid && dropCnt == '0 && !PCSrcE;
    assign bubble         = FlushD || PCSrcE;
    assign pop            = !bubble && !StallD && count != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pcF         <= RESET_PC;
            rspPc       <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);
            if (PCSrcE) begin
                pcF     <= targetF;
                rspPc   <= targetF;
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                // dropCnt is the stale subset of outstanding: after a redirect every
                // request still in flight is stale, including earlier stale ones.
                dropCnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (fire) pcF <= pcF + XLEN'(4);
                if (push) begin
                    rspPc <= rspPc + XLEN'(4);
                    tail  <= nextPtr(tail);
                end
                if (pop) head <= nextPtr(head);
                count <= count + CW'(push) - CW'(pop);
                if (imem_rsp_valid && dropCnt != '0) dropCnt <= dropCnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qInstr[tail] <= imem_rsp_data;
            qPc[tail]    <= rspPc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (bubble) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (pop) begin
            InstrD   <= qInstr[head];
            PCD      <= qPc[head];
            PCPlus4D <= qPc[head] + XLEN'(4);
            ValidD   <= 1'b1;
        end else if (!StallD) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: directed plus randomized checks of fetch_queue_stage against a program-order model
module tb_fetch_queue_stage;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic        reqReady = 1'b1, rspValid = 1'b0, rspValid2 = 1'b0;
    logic [31:0] PCTargetE = '0, rspData = '0, rspData2 = '0;
    logic        reqValid, ValidD, reqValid2, ValidD2;
    logic [31:0] reqAddr, InstrD, PCD, PCPlus4D;
    logic [31:0] reqAddr2, InstrD2, PCD2, PCPlus4D2;

    int          checks = 0, failures = 0, cyc = 0;
    req_t        memQ[$];
    int          latMin = 1, latMax = 1, lastDue = 0;
    logic [31:0] expFetch = '0, expD = '0, expFetch2 = WRAP_PC, expD2 = WRAP_PC;
    int          fireCyc[2];
    int          nFire = 0, firstValid = -1, nValid = 0;
    bit          seenWrap = 0, pend2 = 0;
    logic [31:0] pendAddr2 = '0;

    always #5 clk = ~clk;

    fetch_queue_stage dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .imem_req_valid(reqValid), .imem_req_addr(reqAddr),
        .imem_req_ready(reqReady), .imem_rsp_valid(rspValid), .imem_rsp_data(rspData),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    fetch_queue_stage #(.RESET_PC(WRAP_PC)) dutWrap (
        .clk(clk), .reset(reset), .StallD(1'b0), .FlushD(1'b0), .PCSrcE(1'b0),
        .PCTargetE(32'h0), .imem_req_valid(reqValid2), .imem_req_addr(reqAddr2),
        .imem_req_ready(1'b1), .imem_rsp_valid(rspValid2), .imem_rsp_data(rspData2),
        .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
    );

    function automatic logic [31:0] fn(input logic [31:0] a);
        return a ^ 32'h0000_0100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of memory model, request checks and decode-stage checks.
    task automatic cycle();
        int          inflight, lat;
        bit          wasReset, bub, held, fire2;
        logic [31:0] pI, pP, pP4, a2;
        logic        pV;
        req_t        r;
        inflight = memQ.size();
        rspValid = 1'b0;
        rspData  = '0;
        if (!reset && inflight > 0 && memQ[0].due <= cyc) begin
            r = memQ.pop_front();
            rspValid = 1'b1;
            rspData  = fn(r.addr);
        end
        rspValid2 = pend2;
        rspData2  = fn(pendAddr2);
        #1;
        if (reset) begin
            check("req_valid_in_reset", reqValid, 0);
            check("req_valid_in_reset_wrap", reqValid2, 0);
        end else begin
            if (inflight >= DEPTH) check("credit_full", reqValid, 0);
            if (PCSrcE) check("no_req_on_redirect", reqValid, 0);
            if (reqValid && reqReady) begin
                check("fetch_addr", reqAddr, expFetch);
                expFetch += 4;
                if (nFire < 2) fireCyc[nFire] = cyc;
                nFire++;
                lat = $urandom_range(latMax, latMin);
                r.addr = reqAddr;
                r.due = (cyc + lat > lastDue + 1) ? cyc + lat : lastDue + 1;
                lastDue = r.due;
                memQ.push_back(r);
            end
            if (reqValid2) begin
                check("fetch_addr_wrap", reqAddr2, expFetch2);
                expFetch2 += 4;
            end
            if (PCSrcE) begin
                expFetch = PCTargetE & ~32'h3;
                expD = expFetch;
            end
        end
        fire2 = reqValid2;
        a2 = reqAddr2;
        wasReset = reset;
        bub = FlushD || PCSrcE;
        held = StallD && !bub;
        pI = InstrD; pP = PCD; pP4 = PCPlus4D; pV = ValidD;
        @(posedge clk);
        #1;
        cyc++;
        pend2 = fire2;
        pendAddr2 = a2;
        if (wasReset) begin
            check("rst_InstrD", InstrD, NOP);
            check("rst_PCD", PCD, 0);
            check("rst_PCPlus4D", PCPlus4D, 0);
            check("rst_ValidD", ValidD, 0);
            check("rst_ValidD_wrap", ValidD2, 0);
            memQ.delete();
            lastDue = 0;
            expFetch = '0; expD = '0;
            expFetch2 = WRAP_PC; expD2 = WRAP_PC;
            nFire = 0; firstValid = -1;
        end else begin
            if (bub) begin
                check("bubble_instr", InstrD, NOP);
                check("bubble_valid", ValidD, 0);
                check("bubble_pcd_hold", PCD, pP);
            end else if (held) begin
                check("stall_instr", InstrD, pI);
                check("stall_pcd", PCD, pP);
                check("stall_plus4", PCPlus4D, pP4);
                check("stall_valid", ValidD, pV);
            end else if (ValidD) begin
                check("d_pcd_order", PCD, expD);
                check("d_instr", InstrD, fn(PCD));
                check("d_plus4", PCPlus4D, PCD + 32'd4);
                expD += 4;
                nValid++;
                if (firstValid < 0) firstValid = cyc;
            end
            if (ValidD2) begin
                check("wrap_pcd_order", PCD2, expD2);
                check("wrap_instr", InstrD2, fn(PCD2));
                if (PCD2 == 32'hFFFF_FFFC) begin
                    check("wrap_plus4_zero", PCPlus4D2, 0);
                    seenWrap = 1;
                end
                expD2 += 4;
            end
        end
    endtask

    initial begin
        int          rel, v0;
        bit          found;
        logic [31:0] a0;
        // reset and minimum-latency start-up
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        rel = cyc;
        repeat (4) cycle();
        check("first_fire_cycle", fireCyc[0], rel);
        check("second_fire_cycle", fireCyc[1], rel + 1);
        check("first_valid_latency", firstValid, rel + 3);
        // stall for three cycles at PCD=0x8
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (ValidD && PCD == 32'h8) begin
                found = 1;
                break;
            end
            cycle();
        end
        check("reach_pcd8", found, 1);
        StallD = 1'b1;
        repeat (3) cycle();
        check("stall_hold_instr", InstrD, 32'h108);
        check("stall_hold_pcd", PCD, 32'h8);
        check("stall_credit_stop", reqValid, 0);
        StallD = 1'b0;
        cycle();
        check("resume_pcd", PCD, 32'hC);
        check("resume_valid", ValidD, 1);
        // redirect with two requests in flight, memory latency 3
        latMin = 3;
        latMax = 3;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (memQ.size() == 2) begin
                found = 1;
                break;
            end
            cycle();
        end
        check("two_in_flight", found, 1);
        PCSrcE = 1'b1;
        PCTargetE = 32'h40;
        cycle();
        PCSrcE = 1'b0;
        check("redirect_bubble", ValidD, 0);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (ValidD) begin
                found = 1;
                break;
            end
            cycle();
        end
        check("redirect_progress", found, 1);
        check("redirect_target_pcd", PCD, 32'h40);
        check("redirect_target_instr", InstrD, 32'h140);
        // memory not ready: PCF holds, queue drains
        latMin = 1;
        latMax = 1;
        repeat (8) cycle();
        reqReady = 1'b0;
        a0 = reqAddr;
        repeat (6) begin
            cycle();
            check("addr_stable", reqAddr, a0);
        end
        check("drained_valid", ValidD, 0);
        reqReady = 1'b1;
        // flush and stall together
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (ValidD) begin
                found = 1;
                break;
            end
            cycle();
        end
        check("valid_before_flush", found, 1);
        FlushD = 1'b1;
        StallD = 1'b1;
        cycle();
        FlushD = 1'b0;
        StallD = 1'b0;
        check("flush_over_stall_instr", InstrD, NOP);
        check("flush_over_stall_valid", ValidD, 0);
        // randomized traffic
        latMin = 1;
        latMax = 4;
        v0 = nValid;
        for (int i = 0; i < 600; i++) begin
            StallD    = $urandom_range(99) < 20;
            FlushD    = $urandom_range(99) < 5;
            PCSrcE    = $urandom_range(99) < 6;
            PCTargetE = $urandom & 32'h0000_03FF;
            reqReady  = $urandom_range(99) < 75;
            cycle();
        end
        StallD = 1'b0;
        FlushD = 1'b0;
        PCSrcE = 1'b0;
        reqReady = 1'b1;
        check("random_progress", nValid > v0, 1);
        // reset in the middle of traffic
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (ValidD) begin
                found = 1;
                break;
            end
            cycle();
        end
        check("post_reset_progress", found, 1);
        check("post_reset_pcd", PCD, 32'h0);
        check("wrap_seen", seenWrap, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
